// File: rtl/micro_sequencer.sv
// Next-address controller for the microcoded control store: decodes the
// sequencing field and flags into a command/load address for the micro-address counter.
module micro_sequencer #(
  parameter int                ADDR_W       = 11,
  parameter int                STACK_DEPTH  = 4,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = 11'h000,
  parameter logic [ADDR_W-1:0] FAULT_VECTOR = 11'h7F0
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  input  logic                          stall_i,
  input  logic [2:0]                    seq_op_i,
  input  logic [ADDR_W-1:0]             target_i,
  input  logic [2:0]                    cond_sel_i,
  input  logic [7:0]                    flags_i,
  input  logic [ADDR_W-1:0]             dispatch_addr_i,
  input  logic                          mem_ready_i,
  input  logic [ADDR_W-1:0]             addr_i,
  output logic [1:0]                    cmd_o,
  output logic [ADDR_W-1:0]             load_addr_o,
  output logic                          fault_o,
  output logic [$clog2(STACK_DEPTH):0]  sp_o
);

  // state | meaning
  // BOOT  | reset held or just released; force counter to RESET_VECTOR
  // RUN   | decode seq_op each cycle
  typedef enum logic {BOOT, RUN} state_t;

  localparam int IDX_W = $clog2(STACK_DEPTH);
  localparam int SP_W  = IDX_W + 1;

  localparam logic [1:0] CMD_NONE = 2'd0;
  localparam logic [1:0] CMD_INC  = 2'd1;
  localparam logic [1:0] CMD_LOAD = 2'd2;

  localparam logic [2:0] OP_NEXT     = 3'd0;
  localparam logic [2:0] OP_JUMP     = 3'd1;
  localparam logic [2:0] OP_BRT      = 3'd2;
  localparam logic [2:0] OP_BRF      = 3'd3;
  localparam logic [2:0] OP_DISPATCH = 3'd4;
  localparam logic [2:0] OP_CALL     = 3'd5;
  localparam logic [2:0] OP_RET      = 3'd6;
  localparam logic [2:0] OP_WAIT     = 3'd7;

  state_t            state_q, state_d;
  logic [SP_W-1:0]   sp_q, sp_d;
  logic              fault_q, fault_d;
  logic              push_en;
  logic [ADDR_W-1:0] stack_q [STACK_DEPTH];
  logic [IDX_W-1:0]  push_idx, pop_idx;
  logic [ADDR_W-1:0] ret_addr;
  logic              cond;

  assign cond     = flags_i[cond_sel_i];
  assign push_idx = IDX_W'(sp_q);
  assign pop_idx  = IDX_W'(sp_q - SP_W'(1));
  assign ret_addr = addr_i + ADDR_W'(1);

  always_comb begin
    state_d     = state_q;
    sp_d        = sp_q;
    fault_d     = fault_q;
    push_en     = 1'b0;
    cmd_o       = CMD_NONE;
    load_addr_o = '0;
    case (state_q)
      BOOT: begin
        cmd_o       = CMD_LOAD;
        load_addr_o = RESET_VECTOR;
        state_d     = RUN;
      end
      default: begin
        if (!stall_i) begin
          case (seq_op_i)
            OP_NEXT: cmd_o = CMD_INC;
            OP_JUMP: begin
              cmd_o       = CMD_LOAD;
              load_addr_o = target_i;
            end
            OP_BRT, OP_BRF: begin
              if (cond == (seq_op_i == OP_BRT)) begin
                cmd_o       = CMD_LOAD;
                load_addr_o = target_i;
              end else begin
                cmd_o = CMD_INC;
              end
            end
            OP_DISPATCH: begin
              cmd_o       = CMD_LOAD;
              load_addr_o = dispatch_addr_i;
            end
            OP_CALL: begin
              cmd_o = CMD_LOAD;
              if (sp_q == SP_W'(STACK_DEPTH)) begin
                load_addr_o = FAULT_VECTOR;
                fault_d     = 1'b1;
                sp_d        = '0;
              end else begin
                load_addr_o = target_i;
                push_en     = 1'b1;
                sp_d        = sp_q + SP_W'(1);
              end
            end
            OP_RET: begin
              cmd_o = CMD_LOAD;
              if (sp_q == '0) begin
                load_addr_o = FAULT_VECTOR;
                fault_d     = 1'b1;
              end else begin
                load_addr_o = stack_q[pop_idx];
                sp_d        = sp_q - SP_W'(1);
              end
            end
            default: cmd_o = mem_ready_i ? CMD_INC : CMD_NONE;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= BOOT;
      sp_q    <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      fault_q <= fault_d;
    end
  end

  // Stack contents need no reset; occupancy alone defines validity.
  always_ff @(posedge clk_i) begin
    if (push_en) stack_q[push_idx] <= ret_addr;
  end

  assign fault_o = fault_q;
  assign sp_o    = sp_q;

endmodule

// File: doc/micro_sequencer.md
Name: micro_sequencer

Overview:
Next-address controller for the microcoded CPU control store. Each cycle it decodes the sequencing field of the current microinstruction plus the datapath flags, then drives the command and load address of the micro-address counter. Supports sequential step, jumps, conditional branches, opcode dispatch, subroutine call/return through a small hardware stack, and wait states. Sits between the microcode ROM output and the micro-address counter.

Parameters:
ADDR_W, 11, micro-address width (counter width)
STACK_DEPTH, 4, return-stack entries (power of two, 2..16)
RESET_VECTOR, 11'h000, first micro-address after reset
FAULT_VECTOR, 11'h7F0, micro-address loaded on stack overflow/underflow

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
stall  in  1  global hold; overrides every seq_op
seq_op  in  3  sequencing field of current microinstruction
target  in  ADDR_W  branch/jump/call target field
cond_sel  in  3  selects flags bit for branches
flags  in  8  datapath condition flags
dispatch_addr  in  ADDR_W  entry address from opcode decode map
mem_ready  in  1  wait-state release
addr  in  ADDR_W  current counter value (return-address source)
cmd  out  2  counter command: 0=NONE, 1=INC, 2=LOAD
load_addr  out  ADDR_W  counter load value, meaningful when cmd=LOAD
fault  out  1  sticky stack-error flag
sp  out  $clog2(STACK_DEPTH)+1  stack occupancy (debug)

Behaviour:
- States: BOOT, RUN. reset low (async): state=BOOT, sp=0, fault=0, stack contents don't-care.
- BOOT (also while reset low): cmd=LOAD, load_addr=RESET_VECTOR; next edge with reset high -> RUN. stall ignored in BOOT.
- RUN: cmd/load_addr are combinational from inputs; sp/stack/fault update on rising clk only.
- load_addr=0 whenever cmd!=LOAD (no X propagation).
- cond = flags[cond_sel].
- stall=1: cmd=NONE; no stack/sp/fault change, regardless of seq_op.
- seq_op (stall=0):
  0 NEXT: INC.
  1 JUMP: LOAD target.
  2 BRT: cond=1 -> LOAD target, else INC.
  3 BRF: cond=0 -> LOAD target, else INC.
  4 DISPATCH: LOAD dispatch_addr.
  5 CALL: push (addr+1) mod 2^ADDR_W, LOAD target, sp+1.
  6 RET: pop, LOAD popped value, sp-1.
  7 WAIT: mem_ready=1 -> INC, else NONE.
- Stack is LIFO; push writes entry[sp], pop reads entry[sp-1]. Return address wraps: addr=11'h7FF pushes 11'h000.
- Overflow: CALL with sp=STACK_DEPTH -> no push, cmd=LOAD FAULT_VECTOR, fault<=1, sp<=0.
- Underflow: RET with sp=0 -> cmd=LOAD FAULT_VECTOR, fault<=1, sp<=0.
- fault is sticky; cleared only by reset. Execution continues normally from FAULT_VECTOR.
- Reset asserted mid-CALL/RET: stack state discarded, sp=0, cmd=LOAD RESET_VECTOR immediately (async).
- Latency: cmd/load_addr valid same cycle as seq_op; counter takes new address at next edge; pushed entry readable by RET in following cycle.

Test Plan:
- Reset release -> first cycle cmd=2, load_addr=11'h000; seq_op=0 next cycle -> cmd=1; fault=0, sp=0.
- BRT cond_sel=3, flags=8'h08, target=11'h123 -> cmd=2, load_addr=11'h123; flags=8'h00 -> cmd=1; BRF inverse holds.
- CALL at addr=11'h010, target=11'h200, then RET -> sp 0->1->0, RET load_addr=11'h011; CALL at addr=11'h7FF returns 11'h000.
- Five nested CALLs (depth 4) -> 5th: cmd=2, load_addr=11'h7F0, fault=1, sp=0; RET with sp=0 after reset -> same fault response.
- WAIT with mem_ready=0 for 3 cycles then 1 -> cmd=0,0,0 then 1; stall=1 during CALL -> cmd=0, sp unchanged.
- Assert reset mid-CALL sequence (sp=2) -> cmd=2/load_addr=11'h000 asynchronously, sp=0, fault cleared.
